// File: rtl/bus_responder_8088.sv
// Bus responder for an 8088-style CPU. Watches ALE and the RD/WR/INTA strobes,
// turns each read or write bus cycle into a single backend request with READY
// wait states, returns read data or the interrupt vector on AD_IN, and holds it
// until the strobe is released.
//
// Ports:
//   CORE_CLK_INT, RESET_INT  clock and synchronous active-high reset
//   ALE, RD_n, WR_n, INTA_n  CPU bus controls; IOM selects I/O vs memory
//   AD_OUT                   CPU multiplexed address/data (data on [7:0])
//   AD_IN, DATA_OE           data returned to the CPU and its valid flag
//   READY                    CPU ready; 0 inserts wait states
//   REQ, REQ_WR, REQ_IO      backend request, write flag, I/O flag
//   REQ_ADDR, REQ_WDATA      backend address and write data
//   ACK, RDATA               backend completion and read data
//   INT_VECTOR               vector byte returned on the second INTA pulse
module bus_responder_8088 #(
    parameter int unsigned MIN_WAIT = 0,
    parameter int unsigned ADDR_W   = 20
) (
    input  logic              CORE_CLK_INT,
    input  logic              RESET_INT,
    input  logic              ALE,
    input  logic              RD_n,
    input  logic              WR_n,
    input  logic              INTA_n,
    input  logic              IOM,
    input  logic [19:0]       AD_OUT,
    output logic [7:0]        AD_IN,
    output logic              DATA_OE,
    output logic              READY,
    output logic              REQ,
    output logic              REQ_WR,
    output logic              REQ_IO,
    output logic [ADDR_W-1:0] REQ_ADDR,
    output logic [7:0]        REQ_WDATA,
    input  logic              ACK,
    input  logic [7:0]        RDATA,
    input  logic [7:0]        INT_VECTOR
);

    localparam logic [3:0] MinWait = 4'(MIN_WAIT);

    typedef enum logic [2:0] {StIdle, StCmd, StReq, StHold, StInta} state_e;

    state_e              state_q, state_d;
    logic                ale_q, ale_prev_q, rd_q, rd_prev_q, wr_q, wr_prev_q;
    logic                inta_q, inta_prev_q;
    logic [ADDR_W-1:0]   addr_q, addr_d, req_addr_q, req_addr_d;
    logic                io_q, io_d;
    logic                ready_q, ready_d, data_oe_q, data_oe_d;
    logic                req_q, req_d, req_wr_q, req_wr_d, req_io_q, req_io_d;
    logic [7:0]          req_wdata_q, req_wdata_d, ad_in_q, ad_in_d;
    logic [7:0]          rdata_hold_q, rdata_hold_d;
    logic [3:0]          wait_cnt_q, wait_cnt_d;
    logic                wait_met_q, wait_met_d, ack_seen_q, ack_seen_d;
    logic                abort_q, abort_d;
    logic [1:0]          inta_cnt_q, inta_cnt_d;

    logic ale_fall, rd_fall, wr_fall, inta_fall, rd_rise, wr_rise, inta_rise;
    logic strobe_rise, ack_now, wait_met, abort_now;

    always_comb begin
        ale_fall  = ale_prev_q & ~ale_q;
        rd_fall   = rd_prev_q & ~rd_q;
        wr_fall   = wr_prev_q & ~wr_q;
        inta_fall = inta_prev_q & ~inta_q;
        rd_rise   = ~rd_prev_q & rd_q;
        wr_rise   = ~wr_prev_q & wr_q;
        inta_rise = ~inta_prev_q & inta_q;
        // The strobe that opened the current read/write cycle ends it.
        strobe_rise = req_wr_q ? wr_rise : rd_rise;
        ack_now     = ACK | ack_seen_q;
        wait_met    = wait_met_q | (wait_cnt_q == MinWait);
        abort_now   = abort_q | strobe_rise;

        state_d      = state_q;
        addr_d       = addr_q;
        io_d         = io_q;
        ready_d      = ready_q;
        data_oe_d    = data_oe_q;
        req_d        = req_q;
        req_wr_d     = req_wr_q;
        req_io_d     = req_io_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        ad_in_d      = ad_in_q;
        rdata_hold_d = rdata_hold_q;
        wait_cnt_d   = wait_cnt_q;
        wait_met_d   = wait_met_q;
        ack_seen_d   = ack_seen_q;
        abort_d      = abort_q;
        inta_cnt_d   = inta_cnt_q;

        if (ALE) begin
            addr_d = ADDR_W'(AD_OUT);
            io_d   = IOM;
        end

        unique case (state_q)
            StIdle: begin
                if (ale_fall) state_d = StCmd;
            end
            StCmd: begin
                if (ale_fall) begin
                    state_d = StCmd;
                end else if (rd_fall || (wr_fall && rd_q)) begin
                    // RD_n wins when both strobes are low.
                    state_d     = StReq;
                    req_d       = 1'b1;
                    ready_d     = 1'b0;
                    req_wr_d    = ~rd_fall;
                    req_io_d    = io_q;
                    req_addr_d  = addr_q;
                    wait_cnt_d  = 4'd0;
                    wait_met_d  = 1'b0;
                    ack_seen_d  = 1'b0;
                    abort_d     = 1'b0;
                    if (!rd_fall) req_wdata_d = AD_OUT[7:0];
                end else if (inta_fall) begin
                    state_d    = StInta;
                    inta_cnt_d = 2'd1;
                end
            end
            StReq: begin
                wait_cnt_d = (wait_cnt_q == 4'hF) ? wait_cnt_q : wait_cnt_q + 4'd1;
                wait_met_d = wait_met;
                abort_d    = abort_now;
                if (ACK) begin
                    ack_seen_d   = 1'b1;
                    rdata_hold_d = RDATA;
                end
                if (abort_now && ack_now) begin
                    // Strobe already released: drop the response.
                    state_d = StIdle;
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                end else if (ack_now && wait_met) begin
                    state_d = StHold;
                    req_d   = 1'b0;
                    ready_d = 1'b1;
                    if (!req_wr_q) begin
                        ad_in_d   = ACK ? RDATA : rdata_hold_q;
                        data_oe_d = 1'b1;
                    end
                end
            end
            StHold: begin
                if (strobe_rise) begin
                    data_oe_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StInta: begin
                if (ale_fall) begin
                    inta_cnt_d = 2'd0;
                    data_oe_d  = 1'b0;
                    state_d    = StCmd;
                end else if (inta_fall) begin
                    inta_cnt_d = inta_cnt_q + 2'd1;
                    if (inta_cnt_q == 2'd1) begin
                        ad_in_d   = INT_VECTOR;
                        data_oe_d = 1'b1;
                    end
                end else if (inta_rise && inta_cnt_q == 2'd2) begin
                    data_oe_d  = 1'b0;
                    inta_cnt_d = 2'd0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CORE_CLK_INT) begin
        if (RESET_INT) begin
            state_q      <= StIdle;
            ale_q        <= 1'b0;
            ale_prev_q   <= 1'b0;
            rd_q         <= 1'b1;
            rd_prev_q    <= 1'b1;
            wr_q         <= 1'b1;
            wr_prev_q    <= 1'b1;
            inta_q       <= 1'b1;
            inta_prev_q  <= 1'b1;
            addr_q       <= '0;
            io_q         <= 1'b0;
            ready_q      <= 1'b1;
            data_oe_q    <= 1'b0;
            req_q        <= 1'b0;
            req_wr_q     <= 1'b0;
            req_io_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= 8'h00;
            ad_in_q      <= 8'h00;
            rdata_hold_q <= 8'h00;
            wait_cnt_q   <= 4'd0;
            wait_met_q   <= 1'b0;
            ack_seen_q   <= 1'b0;
            abort_q      <= 1'b0;
            inta_cnt_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            ale_q        <= ALE;
            ale_prev_q   <= ale_q;
            rd_q         <= RD_n;
            rd_prev_q    <= rd_q;
            wr_q         <= WR_n;
            wr_prev_q    <= wr_q;
            inta_q       <= INTA_n;
            inta_prev_q  <= inta_q;
            addr_q       <= addr_d;
            io_q         <= io_d;
            ready_q      <= ready_d;
            data_oe_q    <= data_oe_d;
            req_q        <= req_d;
            req_wr_q     <= req_wr_d;
            req_io_q     <= req_io_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            ad_in_q      <= ad_in_d;
            rdata_hold_q <= rdata_hold_d;
            wait_cnt_q   <= wait_cnt_d;
            wait_met_q   <= wait_met_d;
            ack_seen_q   <= ack_seen_d;
            abort_q      <= abort_d;
            inta_cnt_q   <= inta_cnt_d;
        end
    end

    assign AD_IN     = ad_in_q;
    assign DATA_OE   = data_oe_q;
    assign READY     = ready_q;
    assign REQ       = req_q;
    assign REQ_WR    = req_wr_q;
    assign REQ_IO    = req_io_q;
    assign REQ_ADDR  = req_addr_q;
    assign REQ_WDATA = req_wdata_q;

endmodule

// File: tb/tb_bus_responder_8088.sv
// Self-checking bench: two responders (MIN_WAIT 0 and 3) share one CPU bus,
// each with its own backend model that ACKs a programmed number of REQ cycles
// after the request appears.
module tb_bus_responder_8088;

    localparam int MW1 = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             ale, rd_n, wr_n, inta_n, iom;
    logic [19:0]      ad_out;
    logic [7:0]       int_vector;
    logic [1:0][7:0]  ad_in, req_wdata, rdata;
    logic [1:0][19:0] req_addr;
    logic [1:0]       data_oe, ready, req, req_wr, req_io, ack;

    int checks = 0;
    int errors = 0;

    // Backend model state and observation totals (written only by the monitor).
    int          dly[2];
    logic [7:0]  rval[2];
    bit          busy[2];
    int          n[2];
    int          low_tot[2], oe_tot[2], rise_tot[2], stab_tot[2];
    logic [19:0] cap_addr[2];
    logic        cap_io[2], cap_wr[2];
    logic [7:0]  cap_wdata[2];

    always #5 clk = ~clk;

    bus_responder_8088 #(.MIN_WAIT(0), .ADDR_W(20)) u_dut0 (
        .CORE_CLK_INT(clk), .RESET_INT(rst), .ALE(ale), .RD_n(rd_n), .WR_n(wr_n),
        .INTA_n(inta_n), .IOM(iom), .AD_OUT(ad_out), .AD_IN(ad_in[0]),
        .DATA_OE(data_oe[0]), .READY(ready[0]), .REQ(req[0]), .REQ_WR(req_wr[0]),
        .REQ_IO(req_io[0]), .REQ_ADDR(req_addr[0]), .REQ_WDATA(req_wdata[0]),
        .ACK(ack[0]), .RDATA(rdata[0]), .INT_VECTOR(int_vector)
    );

    bus_responder_8088 #(.MIN_WAIT(MW1), .ADDR_W(20)) u_dut1 (
        .CORE_CLK_INT(clk), .RESET_INT(rst), .ALE(ale), .RD_n(rd_n), .WR_n(wr_n),
        .INTA_n(inta_n), .IOM(iom), .AD_OUT(ad_out), .AD_IN(ad_in[1]),
        .DATA_OE(data_oe[1]), .READY(ready[1]), .REQ(req[1]), .REQ_WR(req_wr[1]),
        .REQ_IO(req_io[1]), .REQ_ADDR(req_addr[1]), .REQ_WDATA(req_wdata[1]),
        .ACK(ack[1]), .RDATA(rdata[1]), .INT_VECTOR(int_vector)
    );

    // Backend model and monitor, sampled on the falling edge.
    initial begin
        ack   = 2'b00;
        rdata = '0;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; n[k] = 0; low_tot[k] = 0; oe_tot[k] = 0;
            rise_tot[k] = 0; stab_tot[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (ready[k] === 1'b0) low_tot[k]++;
                if (data_oe[k] === 1'b1) oe_tot[k]++;
                if (req[k] === 1'b1 && !busy[k]) begin
                    busy[k]      = 1;
                    n[k]         = 0;
                    rise_tot[k]++;
                    cap_addr[k]  = req_addr[k];
                    cap_io[k]    = req_io[k];
                    cap_wr[k]    = req_wr[k];
                    cap_wdata[k] = req_wdata[k];
                end
                if (req[k] === 1'b1) begin
                    if (req_addr[k] !== cap_addr[k] || req_io[k] !== cap_io[k]) stab_tot[k]++;
                    ack[k]   = (n[k] == dly[k]);
                    rdata[k] = ack[k] ? rval[k] : 8'($urandom);
                    n[k]++;
                end else begin
                    busy[k] = 0;
                    ack[k]  = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    task automatic cyc(input int c);
        repeat (c) @(negedge clk);
    endtask

    // Wait states expected for an ACK arriving in REQ cycle d.
    function automatic int exp_low(input int d, input int mw);
        return ((d > mw) ? d : mw) + 1;
    endfunction

    task automatic ale_pulse(input logic io, input logic [19:0] a);
        @(negedge clk);
        ale = 1'b1; iom = io; ad_out = a;
        @(negedge clk);
        ale = 1'b0; ad_out = 20'($urandom);
        @(negedge clk);
    endtask

    // mode: 0 read, 1 write, 2 RD_n and WR_n both low (behaves as read)
    task automatic bus_cycle(input logic io, input logic [19:0] a, input int mode,
                             input logic [7:0] wd, input int d, input logic [7:0] rv,
                             input bit abort, input int e0, input int e1, input string nm);
        int         bl[2], bo[2], br[2], bs[2], el[2];
        logic       hold_oe[2];
        logic [7:0] hold_ad[2];
        el[0] = e0; el[1] = e1;
        for (int k = 0; k < 2; k++) begin
            dly[k] = d; rval[k] = rv;
            bl[k] = low_tot[k]; bo[k] = oe_tot[k]; br[k] = rise_tot[k]; bs[k] = stab_tot[k];
        end
        ale_pulse(io, a);
        ad_out[7:0] = wd;
        rd_n = (mode == 1);
        wr_n = (mode == 0);
        if (abort) begin
            cyc(2);
            rd_n = 1'b1; wr_n = 1'b1;
            cyc(d + 10);
        end else begin
            cyc(d + 12);
            for (int k = 0; k < 2; k++) begin
                hold_oe[k] = data_oe[k];
                hold_ad[k] = ad_in[k];
            end
            rd_n = 1'b1; wr_n = 1'b1;
            cyc(4);
        end
        for (int k = 0; k < 2; k++) begin
            chk({nm, " req_count"}, k, rise_tot[k] - br[k], 1);
            chk({nm, " req_addr"}, k, cap_addr[k], a);
            chk({nm, " req_io"}, k, cap_io[k], io);
            chk({nm, " req_wr"}, k, cap_wr[k], (mode == 1));
            if (mode == 1) chk({nm, " req_wdata"}, k, cap_wdata[k], wd);
            chk({nm, " addr_stable"}, k, stab_tot[k] - bs[k], 0);
            chk({nm, " wait_states"}, k, low_tot[k] - bl[k], el[k]);
            if (abort) begin
                chk({nm, " oe_never"}, k, oe_tot[k] - bo[k], 0);
            end else begin
                chk({nm, " hold_oe"}, k, hold_oe[k], (mode != 1));
                if (mode != 1) chk({nm, " hold_data"}, k, hold_ad[k], rv);
            end
            chk({nm, " end_oe"}, k, data_oe[k], 0);
            chk({nm, " end_ready"}, k, ready[k], 1);
            chk({nm, " end_req"}, k, req[k], 0);
        end
    endtask

    typedef struct {
        logic        io;
        logic [19:0] addr;
        int          mode;
        logic [7:0]  wdata;
        int          d;
        logic [7:0]  rdata;
        bit          abort;
        int          exp_low0;
        int          exp_low1;
        string       name;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int br[2];
        vecs[0] = '{1'b0, 20'h12345, 0, 8'h00, 2, 8'hA5, 1'b0, 3, 4, "mem_read"};
        vecs[1] = '{1'b1, 20'h003F8, 1, 8'h5A, 0, 8'h00, 1'b0, 1, 4, "io_write"};
        vecs[2] = '{1'b0, 20'hABCDE, 0, 8'h00, 0, 8'h77, 1'b0, 1, 4, "ack_early"};
        vecs[3] = '{1'b1, 20'h00060, 0, 8'h00, 5, 8'hC3, 1'b0, 6, 6, "slow_read"};
        vecs[4] = '{1'b0, 20'hF0F0F, 2, 8'hEE, 1, 8'h3C, 1'b0, 2, 4, "rd_wr_both"};
        vecs[5] = '{1'b0, 20'h55555, 1, 8'h81, 3, 8'h00, 1'b0, 4, 4, "mem_write"};
        vecs[6] = '{1'b0, 20'h0BEEF, 0, 8'h00, 6, 8'h99, 1'b1, 7, 7, "abort_read"};

        rst = 1'b1; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; inta_n = 1'b1; iom = 1'b0;
        ad_out = '0; int_vector = 8'h00;
        dly[0] = 99; dly[1] = 99; rval[0] = 8'h00; rval[1] = 8'h00;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        for (int k = 0; k < 2; k++) begin
            chk("rst ready", k, ready[k], 1);
            chk("rst data_oe", k, data_oe[k], 0);
            chk("rst req", k, {req[k], req_wr[k], req_io[k]}, 0);
            chk("rst ad_in", k, ad_in[k], 0);
            chk("rst req_addr", k, req_addr[k], 0);
            chk("rst req_wdata", k, req_wdata[k], 0);
        end

        for (int i = 0; i < 7; i++)
            bus_cycle(vecs[i].io, vecs[i].addr, vecs[i].mode, vecs[i].wdata, vecs[i].d,
                      vecs[i].rdata, vecs[i].abort, vecs[i].exp_low0, vecs[i].exp_low1,
                      vecs[i].name);

        // Interrupt acknowledge: two INTA pulses, no backend request.
        br[0] = rise_tot[0]; br[1] = rise_tot[1];
        ale_pulse(1'b0, 20'h00000);
        inta_n = 1'b0;
        cyc(4);
        for (int k = 0; k < 2; k++) begin
            chk("inta1 data_oe", k, data_oe[k], 0);
            chk("inta1 ready", k, ready[k], 1);
        end
        inta_n = 1'b1;
        cyc(3);
        int_vector = 8'h08;
        inta_n = 1'b0;
        cyc(3);
        int_vector = 8'hFF;
        cyc(1);
        for (int k = 0; k < 2; k++) begin
            chk("inta2 vector", k, ad_in[k], 8'h08);
            chk("inta2 data_oe", k, data_oe[k], 1);
        end
        inta_n = 1'b1;
        cyc(4);
        for (int k = 0; k < 2; k++) begin
            chk("inta end data_oe", k, data_oe[k], 0);
            chk("inta no req", k, rise_tot[k] - br[k], 0);
        end

        // ALE between INTA pulses abandons the acknowledge and starts a new cycle.
        ale_pulse(1'b0, 20'h00000);
        inta_n = 1'b0;
        cyc(4);
        inta_n = 1'b1;
        cyc(2);
        bus_cycle(1'b0, 20'h2468A, 0, 8'h00, 1, 8'h42, 1'b0, 2, 4, "after_inta");

        // Reset in the middle of a request whose ACK never comes.
        dly[0] = 99; dly[1] = 99;
        ale_pulse(1'b1, 20'h13579);
        rd_n = 1'b0;
        cyc(4);
        for (int k = 0; k < 2; k++) chk("pre_rst req", k, req[k], 1);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst ready", k, ready[k], 1);
            chk("mid_rst req", k, req[k], 0);
        end
        rd_n = 1'b1;
        cyc(3);
        bus_cycle(1'b0, 20'h9ABCD, 0, 8'h00, 2, 8'h6E, 1'b0, 3, 4, "post_rst");

        // Randomized bus cycles against the wait-state model.
        for (int i = 0; i < 30; i++) begin
            int r, m, d;
            r = $urandom_range(0, 9);
            m = (r < 5) ? 0 : ((r < 9) ? 1 : 2);
            d = $urandom_range(0, 6);
            bus_cycle(1'($urandom), 20'($urandom), m, 8'($urandom), d, 8'($urandom),
                      1'b0, exp_low(d, 0), exp_low(d, MW1), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_responder_8088.md
BUS_RESPONDER_8088 -- requirements
Module: bus_responder_8088

Interface
REQ-001 Parameter: MIN_WAIT, default 0, minimum READY-low core cycles per read/write before ACK is honoured (0..15).
REQ-002 Parameter: ADDR_W, default 20, width of the latched address.
REQ-003 CORE_CLK_INT  in  1  core clock; all logic rising-edge.
REQ-004 RESET_INT  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 ALE  in  1  address latch enable from CPU.
REQ-006 RD_n / WR_n / INTA_n  in  1 each  active-low read, write and interrupt-acknowledge strobes.
REQ-007 IOM  in  1  1 = I/O cycle, 0 = memory cycle.
REQ-008 AD_OUT  in  20  CPU multiplexed address/data; data on bits 7:0.
REQ-009 AD_IN  out  8  read/vector data returned to CPU.
REQ-010 DATA_OE  out  1  AD_IN valid/driven.
REQ-011 READY  out  1  drives CPU READY_IN; 0 inserts wait states.
REQ-012 REQ / REQ_WR / REQ_IO  out  1 each  backend request, write flag, I/O flag.
REQ-013 REQ_ADDR  out  20; REQ_WDATA  out  8  backend address and write data.
REQ-014 ACK  in  1; RDATA  in  8  backend completion and read data (valid with ACK).
REQ-015 INT_VECTOR  in  8  vector byte for the second INTA pulse.

Function
REQ-016 Strobes are registered once; a falling edge is prev=1 and now=0, a rising edge is prev=0 and now=1; all decisions use registered values (one-cycle input latency).
REQ-017 ALE high: latch AD_OUT into addr and IOM into io every cycle; the value held at ALE falling edge is final.
REQ-018 FSM states IDLE, CMD, REQ, HOLD, INTA.
REQ-019 IDLE: on ALE falling edge -> CMD; READY=1, DATA_OE=0.
REQ-020 CMD: RD_n falling -> REQ with REQ_WR=0; WR_n falling -> REQ with REQ_WR=1, REQ_WDATA captured from AD_OUT[7:0] that cycle; INTA_n falling -> INTA; new ALE falling edge restarts CMD.
REQ-021 REQ entry: READY=0 same cycle as transition, REQ=1, wait counter cleared; REQ held high until ACK sampled with counter >= MIN_WAIT.
REQ-022 ACK when counter < MIN_WAIT: the ACK is remembered and completion occurs when counter reaches MIN_WAIT; counter saturates at 15.
REQ-023 Completion: REQ=0, READY=1 next cycle, read data latched from RDATA into AD_IN with DATA_OE=1 (reads only) -> HOLD.
REQ-024 HOLD: AD_IN/DATA_OE held until strobe rising edge, then DATA_OE=0 -> IDLE.
REQ-025 Strobe rising edge while in REQ (aborted cycle): REQ held until ACK, the response is discarded, READY=1, and the FSM returns to IDLE.
REQ-026 INTA: a pulse counter is incremented on each INTA_n falling edge; 1st pulse: READY=1, DATA_OE=0; 2nd pulse: AD_IN=INT_VECTOR (sampled at falling edge), DATA_OE=1 until INTA_n rising, then the counter clears -> IDLE.
REQ-027 INTA pulses carry no ALE between them; the FSM stays in INTA across both pulses, and an ALE falling edge before the 2nd pulse clears the counter -> CMD.
REQ-028 RD_n and WR_n both low is illegal: treated as read, write ignored.
REQ-029 REQ_ADDR/REQ_IO are stable from REQ assertion until ACK.
REQ-030 Exactly one REQ pulse sequence is issued per bus cycle; a re-asserted strobe without ALE issues none.

Reset
REQ-031 RESET_INT high at a clock edge: state=IDLE, READY=1, DATA_OE=0, REQ=0, REQ_WR=0, REQ_IO=0, AD_IN=0, REQ_ADDR=0, REQ_WDATA=0, counters=0, edge registers=1 (strobes) / 0 (ALE).
REQ-032 Reset mid-operation abandons any outstanding request without waiting for ACK; ACK arriving after reset is ignored in IDLE.

Verification
REQ-033 Memory read, MIN_WAIT=0: ALE addr 0x12345, IOM=0, RD_n low, ACK+RDATA=0xA5 two cycles later -> REQ_ADDR=0x12345, REQ_IO=0, READY low for 3 cycles, AD_IN=0xA5 with DATA_OE=1 until RD_n high.
REQ-034 I/O write: addr 0x003F8, IOM=1, AD_OUT[7:0]=0x5A, WR_n low, immediate ACK -> REQ_WR=1, REQ_IO=1, REQ_WDATA=0x5A, DATA_OE stays 0.
REQ-035 MIN_WAIT=3, ACK held high from REQ start -> READY low exactly 4 cycles, single completion.
REQ-036 INTA sequence, INT_VECTOR=0x08 -> 1st pulse DATA_OE=0; 2nd pulse AD_IN=0x08, DATA_OE=1; no REQ issued.
REQ-037 RESET_INT asserted during REQ with ACK never given -> next cycle READY=1, REQ=0, state IDLE; a following read completes normally.
REQ-038 RD_n released before ACK -> READY returns 1 after ACK, DATA_OE never asserted.
